branch_resolver: RTL and testbench
==================================

# branch_resolver

Mem-stage branch resolution unit; the update and recovery side of the fetch-stage branch predictor. It compares each BEQ/BNE's predicted outcome, which is carried down the pipeline, against the actual outcome. It emits a registered update packet to the predictor, flushes younger instructions, and holds a redirect PC until fetch acknowledges it. It also keeps saturating branch and mispredict counters for performance analysis.

## Interface
Parameters:
- `PC_W`, 32, width of all PC/target fields.
- `CNT_W`, 32, width of the performance counters.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset; synchronous, active-low.
- `stall`  in  1  mem stage stalled; no resolution while high.
- `valid_mem`  in  1  mem-stage instruction is valid (not a bubble).
- `beq_mem`, `bne_mem`  in  1 each  instruction is BEQ / BNE.
- `zero_mem`  in  1  ALU zero flag of the branch compare.
- `pc_mem`  in  PC_W  branch PC.
- `branch_addr_mem`  in  PC_W  computed branch target.
- `pred_taken_mem`  in  1  taken prediction made at fetch.
- `pred_target_mem`  in  PC_W  target predicted at fetch.
- `redirect_ack`  in  1  fetch has loaded `redirect_pc`.
- `upd_valid`  out  1  one-cycle update strobe to the predictor.
- `upd_pc`, `upd_target`  out  PC_W  branch PC and actual branch target.
- `upd_taken`  out  1  actual outcome.
- `branch_mispredict`  out  1  one-cycle pulse, qualified by `upd_valid`.
- `flush_fd`, `flush_de`, `flush_em`  out  1 each  one-cycle flush of the pipeline latches.
- `redirect_valid`  out  1  `redirect_pc` is pending.
- `redirect_pc`  out  PC_W  correct next PC.
- `branch_count`, `mispredict_count`  out  CNT_W  saturating counters.

## Operation
- Resolve event (R): `valid_mem & (beq_mem|bne_mem) & ~stall & state==IDLE`.
- If `beq_mem` and `bne_mem` are both high, `beq_mem` wins.
- Actual outcome:
  - `taken = beq ? zero_mem : ~zero_mem`.
  - `next_pc = taken ? branch_addr_mem : pc_mem + 4`. The add is PC_W bits and wraps modulo 2^PC_W.
- Mispredict: `(pred_taken_mem != taken) | (taken & pred_taken_mem & pred_target_mem != branch_addr_mem)`.
- On R:
  - Register `upd_*` and `branch_mispredict`.
  - `branch_count` increments by 1.
  - `mispredict_count` increments by 1 on a mispredict.
  - Both counters saturate at all-ones and never wrap.
- On R with a mispredict:
  - Pulse all three flush outputs.
  - Load `redirect_pc = next_pc`.
  - Go to REDIRECT.
- On R with a correct prediction: no flush, no redirect; stay IDLE.
- State machine:
  - IDLE -> REDIRECT on a mispredicting R.
  - REDIRECT -> IDLE on the edge that samples `redirect_ack`=1.
  - In REDIRECT, branch inputs are ignored: no update, no count.
  - `stall` does not block the ack.
- `redirect_ack` in IDLE is ignored.
- Non-branch, invalid, or stalled instructions produce no outputs and no count change.

## Timing
- Reset (`nRST`=0 at an edge):
  - Next cycle: state IDLE.
  - All outputs 0, including `redirect_pc`, `upd_*` and both counters.
  - Applies mid-REDIRECT too; the pending redirect is dropped.
- R sampled at edge N: from N+1 for exactly one cycle:
  - `upd_valid`=1.
  - `branch_mispredict` and the flush outputs per outcome.
  - Counters show new values from N+1.
- `redirect_valid`:
  - High from N+1 through the cycle in which `redirect_ack` is sampled high.
  - Low the cycle after.
  - An ack in cycle N+1 gives a one-cycle `redirect_valid`.
- `redirect_pc` is stable while `redirect_valid`=1.
- Earliest next R: the edge after REDIRECT exits. Back-to-back correct-prediction R events give consecutive `upd_valid` pulses.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then BEQ at `pc_mem`=0x40, `zero_mem`=1, target 0x80, `pred_taken_mem`=1, pred target 0x80 -> next cycle:
  - `upd_valid`=1, `upd_taken`=1, `branch_mispredict`=0.
  - No flush.
  - `branch_count`=1.
- BNE at pc 0x100, `zero_mem`=1, pred taken, pred target 0x200 -> next cycle:
  - Mispredict and all flushes pulse.
  - `redirect_pc`=0x104, `redirect_valid`=1.
  - Ack 3 cycles later -> `redirect_valid` low the following cycle.
  - `mispredict_count`=1.
- Taken BEQ, pred taken but pred target 0x300 vs actual 0x340 -> mispredict, `redirect_pc`=0x340.
- Branch held with `stall`=1 for 4 cycles, then `stall`=0 -> exactly one `upd_valid`, one count.
- Second valid branch presented while in REDIRECT -> ignored; assert `nRST`=0 mid-REDIRECT -> next cycle all outputs and counters 0.
- Preload counters to all-ones via 2^CNT_W events (CNT_W=4 build), then one more mispredict -> counters stay 0xF.
- `pc_mem`=0xFFFFFFFC not taken -> `redirect_pc`=0x0.

Source files
------------

// File: rtl/branch_resolver.sv
// Mem-stage branch resolution: checks the fetch-time prediction against the actual
// BEQ/BNE outcome, updates the predictor, flushes on mispredict and holds a redirect PC.
module branch_resolver #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             stall,
    input  logic             valid_mem,
    input  logic             beq_mem,
    input  logic             bne_mem,
    input  logic             zero_mem,
    input  logic [PC_W-1:0]  pc_mem,
    input  logic [PC_W-1:0]  branch_addr_mem,
    input  logic             pred_taken_mem,
    input  logic [PC_W-1:0]  pred_target_mem,
    input  logic             redirect_ack,
    output logic             upd_valid,
    output logic [PC_W-1:0]  upd_pc,
    output logic [PC_W-1:0]  upd_target,
    output logic             upd_taken,
    output logic             branch_mispredict,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;

    logic [0:0]      state;
    logic            is_branch;
    logic            resolve;
    logic            taken;
    logic            target_miss;
    logic            mispredict;
    logic [PC_W-1:0] fallthrough_pc;
    logic [PC_W-1:0] next_pc;

    // Counters stick at all-ones so long runs never read as small values.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        is_branch      = beq_mem | bne_mem;
        resolve        = valid_mem & is_branch & ~stall & (state == IDLE);
        taken          = beq_mem ? zero_mem : ~zero_mem;
        fallthrough_pc = pc_mem + PC_W'(4);
        next_pc        = taken ? branch_addr_mem : fallthrough_pc;
        target_miss    = taken & pred_taken_mem & (pred_target_mem != branch_addr_mem);
        mispredict     = (pred_taken_mem != taken) | target_miss;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state             <= IDLE;
            upd_valid         <= 1'b0;
            upd_pc            <= '0;
            upd_target        <= '0;
            upd_taken         <= 1'b0;
            branch_mispredict <= 1'b0;
            flush_fd          <= 1'b0;
            flush_de          <= 1'b0;
            flush_em          <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
            branch_count      <= '0;
            mispredict_count  <= '0;
        end else begin
            upd_valid         <= 1'b0;
            branch_mispredict <= 1'b0;
            flush_fd          <= 1'b0;
            flush_de          <= 1'b0;
            flush_em          <= 1'b0;

            if (resolve) begin
                upd_valid         <= 1'b1;
                upd_pc            <= pc_mem;
                upd_target        <= branch_addr_mem;
                upd_taken         <= taken;
                branch_mispredict <= mispredict;
                branch_count      <= sat_inc(branch_count);
                if (mispredict) begin
                    mispredict_count <= sat_inc(mispredict_count);
                    flush_fd         <= 1'b1;
                    flush_de         <= 1'b1;
                    flush_em         <= 1'b1;
                    redirect_pc      <= next_pc;
                    redirect_valid   <= 1'b1;
                    state            <= REDIRECT;
                end
            end

            // Ack is honoured regardless of stall; redirect_pc is left as-is.
            if ((state == REDIRECT) && redirect_ack) begin
                redirect_valid <= 1'b0;
                state          <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed scoreboard bench for branch_resolver (CNT_W=4 so saturation is reachable).
module tb_branch_resolver;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;

    logic             CLK;
    logic             nRST;
    logic             stall;
    logic             valid_mem;
    logic             beq_mem;
    logic             bne_mem;
    logic             zero_mem;
    logic [PC_W-1:0]  pc_mem;
    logic [PC_W-1:0]  branch_addr_mem;
    logic             pred_taken_mem;
    logic [PC_W-1:0]  pred_target_mem;
    logic             redirect_ack;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [PC_W-1:0]  upd_target;
    logic             upd_taken;
    logic             branch_mispredict;
    logic             flush_fd;
    logic             flush_de;
    logic             flush_em;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolver #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .stall(stall), .valid_mem(valid_mem),
        .beq_mem(beq_mem), .bne_mem(bne_mem), .zero_mem(zero_mem),
        .pc_mem(pc_mem), .branch_addr_mem(branch_addr_mem),
        .pred_taken_mem(pred_taken_mem), .pred_target_mem(pred_target_mem),
        .redirect_ack(redirect_ack), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken),
        .branch_mispredict(branch_mispredict), .flush_fd(flush_fd),
        .flush_de(flush_de), .flush_em(flush_em), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic            taken;
        logic            mis;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_bc;
    logic [CNT_W-1:0] exp_mc;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, " branch_count"}, 64'(branch_count), 64'(exp_bc));
        chk({tag, " mispredict_count"}, 64'(mispredict_count), 64'(exp_mc));
    endtask

    // Advance one edge, then compare any expected update packet against the outputs.
    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("upd_valid", 64'(upd_valid), 64'd1);
            chk("upd_pc", 64'(upd_pc), 64'(e.pc));
            chk("upd_target", 64'(upd_target), 64'(e.target));
            chk("upd_taken", 64'(upd_taken), 64'(e.taken));
            chk("branch_mispredict", 64'(branch_mispredict), 64'(e.mis));
            chk("flushes", 64'({flush_fd, flush_de, flush_em}), 64'({3{e.mis}}));
        end else begin
            chk("upd_valid quiet", 64'(upd_valid), 64'd0);
            chk("mispredict quiet", 64'(branch_mispredict), 64'd0);
            chk("flushes quiet", 64'({flush_fd, flush_de, flush_em}), 64'd0);
        end
    endtask

    task automatic idle_inputs();
        valid_mem = 1'b0;
        beq_mem   = 1'b0;
        bne_mem   = 1'b0;
    endtask

    // Drive a branch; when a resolve is expected, predict its result from the spec rules.
    task automatic present(input logic beq, input logic bne, input logic zero,
                           input logic [PC_W-1:0] pc, input logic [PC_W-1:0] addr,
                           input logic pt, input logic [PC_W-1:0] ptg, input bit expect_r);
        exp_t e;
        logic tk;
        valid_mem       = 1'b1;
        beq_mem         = beq;
        bne_mem         = bne;
        zero_mem        = zero;
        pc_mem          = pc;
        branch_addr_mem = addr;
        pred_taken_mem  = pt;
        pred_target_mem = ptg;
        if (expect_r) begin
            tk       = beq ? zero : ~zero;
            e.pc     = pc;
            e.target = addr;
            e.taken  = tk;
            e.mis    = (pt != tk) || (tk && pt && (ptg != addr));
            sb.push_back(e);
            if (exp_bc != '1) exp_bc = exp_bc + 1'b1;
            if (e.mis && exp_mc != '1) exp_mc = exp_mc + 1'b1;
        end
    endtask

    initial begin
        nRST = 1'b0; stall = 1'b0; redirect_ack = 1'b0;
        valid_mem = 1'b0; beq_mem = 1'b0; bne_mem = 1'b0; zero_mem = 1'b0;
        pc_mem = '0; branch_addr_mem = '0; pred_taken_mem = 1'b0; pred_target_mem = '0;
        exp_bc = '0; exp_mc = '0;

        tick(); tick();
        chk("reset redirect_valid", 64'(redirect_valid), 64'd0);
        chk("reset redirect_pc", 64'(redirect_pc), 64'd0);
        chk("reset upd_pc", 64'(upd_pc), 64'd0);
        chk_cnt("reset");
        nRST = 1'b1;

        // Correctly predicted taken BEQ.
        present(1'b1, 1'b0, 1'b1, 32'h40, 32'h80, 1'b1, 32'h80, 1'b1);
        tick(); idle_inputs();
        chk_cnt("beq correct");
        chk("beq correct redirect_valid", 64'(redirect_valid), 64'd0);

        // BNE predicted taken but falls through.
        present(1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200, 1'b1);
        tick(); idle_inputs();
        chk("bne mis redirect_valid", 64'(redirect_valid), 64'd1);
        chk("bne mis redirect_pc", 64'(redirect_pc), 64'h104);
        chk_cnt("bne mis");

        // A branch while redirect is pending must be ignored.
        present(1'b1, 1'b0, 1'b1, 32'h500, 32'h600, 1'b0, 32'h0, 1'b0);
        tick(); idle_inputs();
        chk_cnt("ignored in redirect");
        chk("pending redirect_valid", 64'(redirect_valid), 64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold redirect_valid", 64'(redirect_valid), 64'd1);
            chk("hold redirect_pc", 64'(redirect_pc), 64'h104);
        end
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        chk("after ack redirect_valid", 64'(redirect_valid), 64'd0);
        tick();
        chk("idle redirect_valid", 64'(redirect_valid), 64'd0);

        // Taken with wrong predicted target; ack at once while stalled.
        present(1'b1, 1'b0, 1'b1, 32'h2c0, 32'h340, 1'b1, 32'h300, 1'b1);
        tick(); idle_inputs();
        chk("target mis redirect_valid", 64'(redirect_valid), 64'd1);
        chk("target mis redirect_pc", 64'(redirect_pc), 64'h340);
        chk_cnt("target mis");
        stall = 1'b1; redirect_ack = 1'b1;
        tick();
        stall = 1'b0;
        chk("stalled ack redirect_valid", 64'(redirect_valid), 64'd0);
        tick();
        redirect_ack = 1'b0;
        chk("idle ack redirect_valid", 64'(redirect_valid), 64'd0);
        chk_cnt("idle ack");

        // Back-to-back correct predictions.
        present(1'b0, 1'b1, 1'b0, 32'h1000, 32'h1100, 1'b1, 32'h1100, 1'b1);
        tick();
        present(1'b1, 1'b0, 1'b0, 32'h1100, 32'h1180, 1'b0, 32'h0, 1'b1);
        tick(); idle_inputs();
        chk_cnt("back to back");

        // Stalled branch resolves exactly once when released.
        stall = 1'b1;
        present(1'b1, 1'b0, 1'b1, 32'h2000, 32'h2040, 1'b1, 32'h2040, 1'b0);
        repeat (4) tick();
        chk_cnt("during stall");
        stall = 1'b0;
        present(1'b1, 1'b0, 1'b1, 32'h2000, 32'h2040, 1'b1, 32'h2040, 1'b1);
        tick(); idle_inputs();
        tick();
        chk_cnt("after stall");

        // BEQ and BNE both asserted: BEQ semantics.
        present(1'b1, 1'b1, 1'b1, 32'h3000, 32'h3080, 1'b1, 32'h3080, 1'b1);
        tick(); idle_inputs();
        chk("both high redirect_valid", 64'(redirect_valid), 64'd0);

        // Non-branch and invalid slots.
        valid_mem = 1'b1; beq_mem = 1'b0; bne_mem = 1'b0;
        tick();
        valid_mem = 1'b0; beq_mem = 1'b1;
        tick(); idle_inputs();
        chk_cnt("non-branch");

        // Fall-through PC wraps.
        present(1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h10, 1'b1, 32'h10, 1'b1);
        tick(); idle_inputs();
        chk("wrap redirect_valid", 64'(redirect_valid), 64'd1);
        chk("wrap redirect_pc", 64'(redirect_pc), 64'h0);
        chk_cnt("wrap");
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
        chk("wrap ack redirect_valid", 64'(redirect_valid), 64'd0);

        // Drive both counters into saturation.
        for (int i = 0; i < 16; i++) begin
            present(1'b1, 1'b0, 1'b1, 32'h4000, 32'h4040, 1'b1, 32'h4040, 1'b1);
            tick();
        end
        idle_inputs();
        chk_cnt("branch saturate");
        for (int i = 0; i < 16; i++) begin
            present(1'b1, 1'b0, 1'b1, 32'h5000, 32'h5040, 1'b0, 32'h0, 1'b1);
            tick(); idle_inputs();
            redirect_ack = 1'b1;
            tick();
            redirect_ack = 1'b0;
        end
        chk_cnt("mispredict saturate");
        present(1'b0, 1'b1, 1'b0, 32'h6000, 32'h6100, 1'b0, 32'h0, 1'b1);
        tick(); idle_inputs();
        chk_cnt("past saturation");
        chk("saturated redirect_pc", 64'(redirect_pc), 64'h6100);

        // Reset in the middle of a pending redirect.
        present(1'b1, 1'b0, 1'b1, 32'h7000, 32'h7040, 1'b0, 32'h0, 1'b0);
        tick(); idle_inputs();
        nRST = 1'b0;
        tick();
        exp_bc = '0; exp_mc = '0;
        chk_cnt("mid-redirect reset");
        chk("reset2 redirect_valid", 64'(redirect_valid), 64'd0);
        chk("reset2 redirect_pc", 64'(redirect_pc), 64'd0);
        chk("reset2 upd_pc", 64'(upd_pc), 64'd0);
        chk("reset2 upd_target", 64'(upd_target), 64'd0);
        chk("reset2 upd_taken", 64'(upd_taken), 64'd0);
        nRST = 1'b1;

        present(1'b1, 1'b0, 1'b1, 32'h8000, 32'h8040, 1'b1, 32'h8040, 1'b1);
        tick(); idle_inputs();
        chk_cnt("post reset");
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
